sw_event_scanner: RTL and testbench
===================================

Name: sw_event_scanner

Overview:
- Sequences a round-robin scan over the 24 debounced switch lines.
- Detects per-switch level changes and queues each change as an event {index, new level} in an internal FIFO.
- Presents queued events to one consumer (game/control FSM) over a valid/ready handshake, so the consumer reads single changes instead of polling a 24-bit bus.
- Sits directly downstream of the debounced switch bus; also exports the scanner's current view of all switch levels.

Parameters:
- N_SW, 24, number of switch lines scanned.
- IDX_W, 5, width of the event index; must satisfy 2^IDX_W >= N_SW.
- SCAN_DIV, 1, clock cycles per scan step; 1 = one switch examined every cycle.
- FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- sw_link  input  N_SW  debounced switch levels, already synchronous to clk.
- scan_en  input  1  1 = scanner advances; 0 = scanner holds its position while the FIFO still drains.
- evt_valid  output  1  FIFO head holds an event.
- evt_idx  output  IDX_W  switch index of the head event.
- evt_level  output  1  new level of that switch.
- evt_ready  input  1  consumer accepts the head event.
- sw_state  output  N_SW  scanner's committed view of the switch levels.
- evt_count  output  IDX_W+1 (clamped to cover FIFO_DEPTH)  number of queued events.

Behaviour:
- Reset, sampled on the clk edge with rst=1:
  - state=INIT; scan index=0; divider=0; FIFO empty.
  - evt_valid=0, evt_idx=0, evt_level=0, evt_count=0, sw_state=0.
- INIT:
  - Lasts exactly one cycle after rst deasserts.
  - sw_state <= sw_link, then state=SCAN.
  - Generates no events, so switches that are already on at power-up produce none.
- SCAN, divider:
  - Counts 0..SCAN_DIV-1 while scan_en=1.
  - step = (divider==SCAN_DIV-1) && scan_en.
  - With scan_en=0 the divider holds its value.
- SCAN, on a step, index i examined:
  - sw_link[i]==sw_state[i]: i advances; no push.
  - Differs and FIFO not full: push {i, sw_link[i]}; sw_state[i] <= sw_link[i]; i advances.
  - Differs and FIFO full: stall. i, sw_state and the divider all hold, and the same index is re-examined every cycle until space appears. No event is ever dropped.
- Index wraps N_SW-1 -> 0. Values >= N_SW never occur.
- A switch that toggles twice between visits compares equal and emits nothing. This is accepted behaviour: it is a sample of level, not a capture of every edge.
- FIFO:
  - A pop occurs when evt_valid && evt_ready.
  - Push and pop in the same cycle: both occur, count unchanged.
  - "Full" is evaluated on the registered count, so a pop in the same cycle does not enable a push into a full FIFO; the push happens the next cycle.
  - evt_idx and evt_level are valid whenever evt_valid=1. They are 0 when the FIFO is empty.
  - evt_ready with evt_valid=0: ignored.
- Latency:
  - Switch change to push: at most N_SW*SCAN_DIV cycles when not stalled.
  - Push to evt_valid: 1 cycle (registered FIFO count).
- evt_count: 0..FIFO_DEPTH; +1 per push, -1 per pop.
- Reset mid-operation: the FIFO contents and in-flight events are discarded, then the INIT re-snapshot is taken; no event reflects pre-reset state.

Test Plan:
- Power-up snapshot: sw_link=24'h000005, release rst -> evt_valid stays 0 for 100 cycles; sw_state=24'h000005.
- Single change (SCAN_DIV=1): after INIT set sw_link[7]=1, evt_ready=1 -> exactly one event {idx=7, level=1} within 25 cycles; sw_state[7]=1. Clear bit 7 -> event {7, 0}.
- Multiple changes ordering: from 0, set bits 3, 10, 20 in one cycle while the index is at 0 -> events arrive in order 3, 10, 20; evt_count peaks at 3 when evt_ready=0.
- Full/stall: FIFO_DEPTH=8, evt_ready=0, toggle bits 0..9 -> evt_count=8, the scanner stalls at index 8 with sw_state[8]=0. Raise evt_ready -> events 8 and 9 follow; 10 total, none lost.
- Simultaneous push/pop plus scan_en: evt_ready=1 with changes arriving every cycle -> evt_count never exceeds 1. scan_en=0 for 50 cycles with bit 5 toggled -> no event until scan_en=1.
- Reset mid-operation: 4 events queued, assert rst 1 cycle with sw_link=24'hFFFFFF -> evt_count=0, evt_valid=0, sw_state=24'hFFFFFF, no events afterward.

Source files
------------

// File: rtl/sw_event_scanner.sv
// -----------------------------------------------------------------------------
// sw_event_scanner
//
// Purpose:
//   Scans the debounced switch bus one line at a time in round-robin order.
//   It compares each line with the scanner's committed view of that switch.
//   Every change is queued as an event {index, new level} in a small FIFO,
//   which a single consumer drains over a valid/ready handshake. A change found
//   while the FIFO is full stalls the scan on that index, so no event is lost.
//
// Ports:
//   clk        in   system clock (single domain)
//   rst        in   synchronous, active-high reset
//   sw_link    in   [N_SW]     debounced switch levels, synchronous to clk
//   scan_en    in   1 = scanner advances, 0 = scanner holds (FIFO still drains)
//   evt_valid  out  FIFO head holds an event
//   evt_idx    out  [IDX_W]    switch index of the head event (0 when empty)
//   evt_level  out  new level of that switch (0 when empty)
//   evt_ready  in   consumer accepts the head event
//   sw_state   out  [N_SW]     scanner's committed view of the switch levels
//   evt_count  out  [CNT_W]    number of queued events (0..FIFO_DEPTH)
// -----------------------------------------------------------------------------
module sw_event_scanner #(
    parameter int N_SW       = 24,
    parameter int IDX_W      = 5,
    parameter int SCAN_DIV   = 1,
    parameter int FIFO_DEPTH = 8,
    localparam int CNT_W     = ((IDX_W + 1) > $clog2(FIFO_DEPTH + 1)) ?
                               (IDX_W + 1) : $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SW-1:0]   sw_link,
    input  logic              scan_en,
    output logic              evt_valid,
    output logic [IDX_W-1:0]  evt_idx,
    output logic              evt_level,
    input  logic              evt_ready,
    output logic [N_SW-1:0]   sw_state,
    output logic [CNT_W-1:0]  evt_count
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EVT_W = IDX_W + 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SW - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DIV_W-1:0]  r_div;
    logic [N_SW-1:0]   r_sw_state;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [EVT_W-1:0]  r_mem [FIFO_DEPTH];

    logic              w_step;
    logic              w_diff;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_stall;
    logic              w_advance;
    logic              w_valid;
    logic [EVT_W-1:0]  w_head;

    // Fullness is taken from the registered count, so a pop in the same cycle
    // never frees a slot for a simultaneous push; that push lands next cycle.
    assign w_full    = (r_count == CNT_FULL);
    assign w_valid   = (r_count != '0);
    assign w_step    = (r_state == ST_SCAN) && (r_div == DIV_LAST) && scan_en;
    assign w_diff    = (sw_link[r_idx] != r_sw_state[r_idx]);
    assign w_push    = w_step && w_diff && !w_full;
    assign w_stall   = w_step && w_diff && w_full;
    assign w_advance = w_step && !w_stall;
    assign w_pop     = w_valid && evt_ready;
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_idx      <= '0;
            r_div      <= '0;
            r_sw_state <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // Snapshot the bus so levels present at power-up are not events.
                    r_sw_state <= sw_link;
                    r_state    <= ST_SCAN;
                end
                ST_SCAN: begin
                    // A stall freezes the divider too, so the blocked index is
                    // re-examined on every cycle until the FIFO has room.
                    if (scan_en && !w_stall) begin
                        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
                    end
                    if (w_push) begin
                        r_sw_state[r_idx] <= sw_link[r_idx];
                    end
                    if (w_advance) begin
                        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= ST_INIT;
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Event storage carries only data; the pointers and the count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_idx, sw_link[r_idx]};
        end
    end

    assign evt_valid = w_valid;
    assign evt_idx   = w_valid ? w_head[EVT_W-1:1] : '0;
    assign evt_level = w_valid ? w_head[0] : 1'b0;
    assign sw_state  = r_sw_state;
    assign evt_count = r_count;

endmodule

// File: tb/tb_sw_event_scanner.sv
module tb_sw_event_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] sw_link;
    logic        scan_en;
    logic        evt_valid;
    logic [4:0]  evt_idx;
    logic        evt_level;
    logic        evt_ready;
    logic [23:0] sw_state;
    logic [5:0]  evt_count;

    int n_checks = 0;
    int n_fail   = 0;

    // popped events, packed as {idx[4:0], level}
    logic [5:0] q_evt[$];

    sw_event_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .sw_link   (sw_link),
        .scan_en   (scan_en),
        .evt_valid (evt_valid),
        .evt_idx   (evt_idx),
        .evt_level (evt_level),
        .evt_ready (evt_ready),
        .sw_state  (sw_state),
        .evt_count (evt_count)
    );

    always #5 clk = ~clk;

    // Inputs change only #1 after posedge, so at negedge a valid&&ready pair
    // is exactly what the next posedge will pop.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            q_evt.push_back({evt_idx, evt_level});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Wait until at least n events were popped, bounded by a cycle budget.
    task automatic wait_events(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (q_evt.size() < n && c < budget) begin
            tick();
            c++;
        end
        check(tag, q_evt.size(), n);
    endtask

    // Reset, then the INIT cycle; afterwards the scan index is 0.
    task automatic do_reset(input logic [23:0] lvl);
        rst     = 1'b1;
        sw_link = lvl;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int vcnt;
        int maxc;

        rst       = 1'b1;
        sw_link   = 24'h000005;
        scan_en   = 1'b1;
        evt_ready = 1'b0;
        ticks(2);

        // Reset state
        check("rst_valid", evt_valid, 0);
        check("rst_count", evt_count, 0);
        check("rst_sw_state", sw_state, 0);
        check("rst_idx", evt_idx, 0);
        check("rst_level", evt_level, 0);

        // Power-up snapshot: levels present at INIT produce no events
        rst = 1'b0;
        tick();
        check("init_sw_state", sw_state, 24'h000005);
        vcnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (evt_valid) vcnt++;
        end
        check("init_no_events", vcnt, 0);
        check("init_sw_state_hold", sw_state, 24'h000005);

        // Single change, then clear it again
        q_evt.delete();
        evt_ready = 1'b1;
        sw_link   = 24'h000085;
        wait_events("single_rise_n", 1, 25);
        check("single_rise_evt", q_evt[0], {5'd7, 1'b1});
        check("single_rise_state", sw_state, 24'h000085);
        ticks(30);
        check("single_rise_once", q_evt.size(), 1);
        q_evt.delete();
        sw_link = 24'h000005;
        wait_events("single_fall_n", 1, 25);
        check("single_fall_evt", q_evt[0], {5'd7, 1'b0});
        check("single_fall_state", sw_state, 24'h000005);

        // Several changes in one cycle with the index at 0: order follows the scan
        evt_ready = 1'b0;
        do_reset(24'h000000);
        q_evt.delete();
        sw_link = 24'h100408;
        maxc = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (int'(evt_count) > maxc) maxc = int'(evt_count);
        end
        check("multi_peak", maxc, 3);
        check("multi_head_idx", evt_idx, 3);
        evt_ready = 1'b1;
        wait_events("multi_n", 3, 10);
        check("multi_e0", q_evt[0], {5'd3, 1'b1});
        check("multi_e1", q_evt[1], {5'd10, 1'b1});
        check("multi_e2", q_evt[2], {5'd20, 1'b1});

        // FIFO full: scan stalls on index 8 until the consumer drains
        evt_ready = 1'b0;
        do_reset(24'h000000);
        q_evt.delete();
        sw_link = 24'h0003FF;
        ticks(40);
        check("full_count", evt_count, 8);
        check("full_sw_state", sw_state, 24'h0000FF);
        check("full_sw8", sw_state[8], 1'b0);
        evt_ready = 1'b1;
        wait_events("full_drain_n", 10, 60);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("full_e%0d", k), (k < q_evt.size()) ? q_evt[k] : 6'h3F,
                  {5'(k), 1'b1});
        end
        ticks(30);
        check("full_none_lost", q_evt.size(), 10);
        check("full_final_state", sw_state, 24'h0003FF);
        check("full_empty", evt_count, 0);

        // Back-to-back changes with the consumer always ready
        sw_link = 24'hFFFFFF;
        ticks(30);
        q_evt.delete();
        sw_link = 24'h000000;
        maxc = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (int'(evt_count) > maxc) maxc = int'(evt_count);
        end
        check("b2b_max_count", maxc, 1);
        check("b2b_events", q_evt.size(), 24);
        check("b2b_state", sw_state, 24'h000000);

        // scan_en=0 freezes the scan
        q_evt.delete();
        scan_en = 1'b0;
        sw_link = 24'h000020;
        vcnt = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (evt_valid) vcnt++;
        end
        check("hold_no_valid", vcnt, 0);
        check("hold_state", sw_state, 24'h000000);
        scan_en = 1'b1;
        wait_events("hold_resume_n", 1, 30);
        check("hold_resume_evt", q_evt[0], {5'd5, 1'b1});

        // Reset mid-operation discards queued events
        evt_ready = 1'b0;
        sw_link   = 24'h000F20;
        ticks(30);
        check("mid_queued", evt_count, 4);
        q_evt.delete();
        rst     = 1'b1;
        sw_link = 24'hFFFFFF;
        tick();
        check("mid_rst_count", evt_count, 0);
        check("mid_rst_valid", evt_valid, 0);
        rst = 1'b0;
        tick();
        check("mid_snapshot", sw_state, 24'hFFFFFF);
        evt_ready = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (evt_valid) vcnt++;
        end
        check("mid_no_events", vcnt, 0);
        check("mid_no_pops", q_evt.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
